clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode and alarm controller for the digital clock. It sequences the run, time-set and alarm-set modes, and converts the two push-buttons into one-cycle increment strobes for the minute/hour counters. It also holds the alarm time, drives field-blink masks to the segment scanner, and raises the beeper request when the running time matches the alarm. It sits between the clock dividers/buttons and the BCD time counters, display scanner and Beeper.

## Interface
Parameters:
- TIMEOUT_S, 16: seconds without a button press before a set mode returns to RUN
- BEEP_S, 60: alarm beep duration in seconds
- REPEAT_DLY, 2: tick_4hz periods of hold before auto-repeat starts

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle strobe, 1 Hz, from divider
- tick_4hz  in  1  one-cycle strobe, 4 Hz, from divider
- btn_mode  in  1  debounced, synchronized level, high = pressed
- btn_inc  in  1  debounced, synchronized level, high = pressed
- alarm_en  in  1  alarm enable switch
- cur_h_t, cur_h_o, cur_m_t, cur_m_o  in  4 each  current time, BCD
- cur_sec_zero  in  1  high while seconds = 00
- run_en  out  1  time counters may count
- inc_min, inc_hour  out  1  one-cycle increment strobes to counters
- alm_h_t, alm_h_o, alm_m_t, alm_m_o  out  4 each  alarm time register, BCD
- disp_alarm  out  1  display shows the alarm register instead of the time
- blank  out  6  per-digit blank: [5:4] hour, [3:2] min, [1:0] sec
- beep  out  1  beeper request
- mode  out  3  current state code

## Operation
- States: RUN=0, SET_HOUR=1, SET_MIN=2, ALM_HOUR=3, ALM_MIN=4.
- btn_mode rising edge advances the state: RUN→SET_HOUR→SET_MIN→ALM_HOUR→ALM_MIN→RUN.
- btn_inc action per state:
  - SET_HOUR: pulse inc_hour.
  - SET_MIN: pulse inc_min.
  - ALM_HOUR: alarm hour +1, wraps 23→00.
  - ALM_MIN: alarm minute +1, wraps 59→00.
  - RUN: no increment.
- Auto-repeat: btn_inc held for REPEAT_DLY tick_4hz strobes, then one further increment on each following tick_4hz while held.
- run_en is 1 only in RUN. Time is frozen while it is being set.
- disp_alarm is 1 in ALM_HOUR and ALM_MIN.
- Blink phase toggles on every tick_4hz (2 Hz blink). While the phase is 1, the two digits of the edited field are blanked (bits 5:4 or 3:2). All other blank bits are 0.
- Timeout: the counter clears on any button edge and advances on tick_1hz in set states. When it reaches TIMEOUT_S, the state goes to RUN.
- Alarm:
  - In RUN with alarm_en=1, match (cur_h = alm_h, cur_m = alm_m, cur_sec_zero=1) sets beep_active and loads the beep counter.
  - beep_active clears when BEEP_S tick_1hz strobes have elapsed, on a btn_inc rising edge, on alarm_en=0, or on leaving RUN.
  - beep = beep_active.
- Alarm values are always legal BCD: hour 00–23, minute 00–59.

## Timing
- Reset values: mode=RUN, alarm 00:00, run_en=1, inc_*=0, blank=0, disp_alarm=0, beep=0, blink phase=0, timeout and repeat counters 0.
- A button sampled high at edge N (low at N-1) produces its effect from edge N+1:
  - inc_* high for exactly cycle N+1, or
  - alarm register / mode updated at N+1.
- btn_mode and btn_inc rising in the same cycle: mode advances and the increment is discarded.
- A btn_inc edge that silences an active beep is consumed and causes no other action.
- Holding btn_mode does not repeat.
- A match persisting through the whole second 00 re-triggers nothing after a silence, because cur_sec_zero is only honoured when it rises.
- A tick_4hz coinciding with a press edge yields one increment only.
- rst mid-operation returns every register to its reset value on the next edge.

## Structure
- Shared package holds:
  - the state enum encoding,
  - the blank bit-field positions,
  - the constants MAX_HOUR=23 and MAX_MIN=59.
- Sub-module key_repeat, instantiated once for btn_inc:
  - edge detect, hold counter and repeat strobe on tick_4hz;
  - output is one-cycle press/repeat pulses.
- btn_mode uses a plain edge detect.
- BCD wrap-increment is a function in the package.

## Test plan
- Reset, then btn_mode pressed 5 times → mode sequence 1,2,3,4,0; disp_alarm=1 only in modes 3 and 4.
- SET_MIN, press btn_inc once → inc_min high exactly 1 cycle after the edge; run_en=0.
- ALM_HOUR at 23, press btn_inc → alarm hour 00. ALM_MIN at 59, press → alarm minute 00. Hour unchanged.
- ALM_MIN, hold btn_inc for 8 tick_4hz → 1 + (8−REPEAT_DLY) = 7 increments.
- Set alarm 07:30, RUN, alarm_en=1, drive time 07:30:00 → beep rises next cycle and falls after 60 tick_1hz. Repeat the match with a btn_inc press → beep drops next cycle.
- SET_HOUR idle for 16 tick_1hz → mode=0. btn_mode and btn_inc rising in the same cycle → mode advances and no inc_hour pulse.

Source files
------------

// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the clock mode/alarm controller: state codes,
// blank-field positions, time limits and the BCD wrap-increment helper.
package clock_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        ALM_HOUR = 3'd3,
        ALM_MIN  = 3'd4
    } mode_t;

    localparam int BLANK_HOUR_LSB = 4;
    localparam int BLANK_MIN_LSB  = 2;
    localparam int BLANK_SEC_LSB  = 0;
    localparam logic [5:0] BLANK_HOUR_MASK = 6'b000011 << BLANK_HOUR_LSB;
    localparam logic [5:0] BLANK_MIN_MASK  = 6'b000011 << BLANK_MIN_LSB;
    localparam logic [5:0] BLANK_SEC_MASK  = 6'b000011 << BLANK_SEC_LSB;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    // Two-digit BCD increment that wraps to 00 after reaching max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input int max);
        logic [3:0] max_t;
        logic [3:0] max_o;
        max_t = 4'(max / 10);
        max_o = 4'(max % 10);
        if (val[7:4] == max_t && val[3:0] == max_o)
            return 8'h00;
        else if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        else
            return {val[7:4], val[3:0] + 4'd1};
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return ALM_HOUR;
            ALM_HOUR: return ALM_MIN;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_key_repeat.sv
// Button edge detector with hold-to-repeat: emits one-cycle pulses for the
// press itself and for every tick after REPEAT_DLY ticks of continuous hold.
module key_repeat #(
    parameter int REPEAT_DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic tick,
    output logic press,
    output logic pulse
);

    localparam int CW = $clog2(REPEAT_DLY + 2);
    localparam logic [CW-1:0] HOLD_LAST = CW'(REPEAT_DLY);

    logic          btn_q;
    logic [CW-1:0] hold_cnt;

    // A tick landing on the press cycle itself is not a hold tick, so it never doubles up.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q    <= 1'b0;
            press    <= 1'b0;
            pulse    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            btn_q <= btn;
            press <= btn & ~btn_q;
            pulse <= btn & ~btn_q;
            if (!(btn && btn_q)) begin
                hold_cnt <= '0;
            end else if (tick) begin
                if (hold_cnt == HOLD_LAST)
                    pulse <= 1'b1;
                else
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer and alarm controller for the digital clock: set-mode FSM,
// increment strobes, alarm register, blink masks and beeper request.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S  = 16,
    parameter int BEEP_S     = 60,
    parameter int REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_4hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_en,
    input  logic [3:0] cur_h_t,
    input  logic [3:0] cur_h_o,
    input  logic [3:0] cur_m_t,
    input  logic [3:0] cur_m_o,
    input  logic       cur_sec_zero,
    output logic       run_en,
    output logic       inc_min,
    output logic       inc_hour,
    output logic [3:0] alm_h_t,
    output logic [3:0] alm_h_o,
    output logic [3:0] alm_m_t,
    output logic [3:0] alm_m_o,
    output logic       disp_alarm,
    output logic [5:0] blank,
    output logic       beep,
    output logic [2:0] mode
);

    localparam int TO_W   = $clog2(TIMEOUT_S + 1);
    localparam int BEEP_W = $clog2(BEEP_S + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_S - 1);
    localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_S);

    mode_t             state;
    logic              mode_q;
    logic              mode_press;
    logic              inc_press;
    logic              inc_pulse;
    logic              sz_q;
    logic              phase;
    logic              beep_active;
    logic [TO_W-1:0]   to_cnt;
    logic [BEEP_W-1:0] beep_cnt;
    logic [7:0]        alm_h;
    logic [7:0]        alm_m;
    logic              timeout_hit;
    logic              alarm_match;
    logic              beep_clear;

    key_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_inc_key (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .tick  (tick_4hz),
        .press (inc_press),
        .pulse (inc_pulse)
    );

    assign timeout_hit = (state != RUN) && tick_1hz && (to_cnt == TO_LAST)
                         && !mode_press && !inc_press;
    assign alarm_match = (state == RUN) && alarm_en && cur_sec_zero && !sz_q
                         && ({cur_h_t, cur_h_o} == alm_h) && ({cur_m_t, cur_m_o} == alm_m);
    assign beep_clear  = !alarm_en || inc_press || mode_press || (state != RUN);

    // Mode key edge, seconds-zero rise and the 2 Hz blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            mode_press <= 1'b0;
            sz_q       <= 1'b0;
            phase      <= 1'b0;
        end else begin
            mode_q     <= btn_mode;
            mode_press <= btn_mode & ~mode_q;
            sz_q       <= cur_sec_zero;
            if (tick_4hz)
                phase <= ~phase;
        end
    end

    // Mode press beats timeout, which beats any increment landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            to_cnt   <= '0;
            alm_h    <= 8'h00;
            alm_m    <= 8'h00;
            inc_min  <= 1'b0;
            inc_hour <= 1'b0;
        end else begin
            inc_min  <= 1'b0;
            inc_hour <= 1'b0;
            if (mode_press) begin
                state  <= next_mode(state);
                to_cnt <= '0;
            end else if (timeout_hit) begin
                state  <= RUN;
                to_cnt <= '0;
            end else begin
                if (inc_press)
                    to_cnt <= '0;
                else if (state != RUN && tick_1hz)
                    to_cnt <= to_cnt + 1'b1;
                if (inc_pulse) begin
                    case (state)
                        SET_HOUR: inc_hour <= 1'b1;
                        SET_MIN:  inc_min  <= 1'b1;
                        ALM_HOUR: alm_h    <= bcd_inc(alm_h, MAX_HOUR);
                        ALM_MIN:  alm_m    <= bcd_inc(alm_m, MAX_MIN);
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Beeper: any silencing condition wins over a fresh match on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            beep_active <= 1'b0;
            beep_cnt    <= '0;
        end else if (beep_clear) begin
            beep_active <= 1'b0;
        end else if (alarm_match) begin
            beep_active <= 1'b1;
            beep_cnt    <= BEEP_LOAD;
        end else if (beep_active && tick_1hz) begin
            if (beep_cnt == BEEP_W'(1))
                beep_active <= 1'b0;
            beep_cnt <= beep_cnt - 1'b1;
        end
    end

    always_comb begin
        blank = '0;
        if (phase) begin
            case (state)
                SET_HOUR, ALM_HOUR: blank = BLANK_HOUR_MASK;
                SET_MIN, ALM_MIN:   blank = BLANK_MIN_MASK;
                default:            blank = '0;
            endcase
        end
    end

    assign run_en     = (state == RUN);
    assign disp_alarm = (state == ALM_HOUR) || (state == ALM_MIN);
    assign mode       = state;
    assign beep       = beep_active;
    assign alm_h_t    = alm_h[7:4];
    assign alm_h_o    = alm_h[3:0];
    assign alm_m_t    = alm_m[7:4];
    assign alm_m_o    = alm_m[3:0];

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_clock_mode_ctrl;

    localparam int TIMEOUT_S  = 16;
    localparam int BEEP_S     = 60;
    localparam int REPEAT_DLY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_4hz = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, alarm_en = 1'b0;
    logic [3:0] cur_h_t = '0, cur_h_o = '0, cur_m_t = '0, cur_m_o = '0;
    logic       cur_sec_zero = 1'b0;
    logic       run_en, inc_min, inc_hour, disp_alarm, beep;
    logic [3:0] alm_h_t, alm_h_o, alm_m_t, alm_m_o;
    logic [5:0] blank;
    logic [2:0] mode;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    clock_mode_ctrl #(.TIMEOUT_S(TIMEOUT_S), .BEEP_S(BEEP_S), .REPEAT_DLY(REPEAT_DLY)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_4hz(tick_4hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .alarm_en(alarm_en),
        .cur_h_t(cur_h_t), .cur_h_o(cur_h_o), .cur_m_t(cur_m_t), .cur_m_o(cur_m_o),
        .cur_sec_zero(cur_sec_zero), .run_en(run_en), .inc_min(inc_min), .inc_hour(inc_hour),
        .alm_h_t(alm_h_t), .alm_h_o(alm_h_o), .alm_m_t(alm_m_t), .alm_m_o(alm_m_o),
        .disp_alarm(disp_alarm), .blank(blank), .beep(beep), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: mode as 0..4, alarm as plain integers, key effects one edge late.
    int m_mode = 0, m_ah = 0, m_am = 0, m_phase = 0, m_beep = 0, m_left = 0;
    int m_idle = 0, m_held = 0, m_inc_min = 0, m_inc_hour = 0;
    bit prev_bm = 0, prev_bi = 0, prev_sz = 0, pend_mode = 0, pend_press = 0, pend_rep = 0;

    always @(posedge clk) begin : model
        int  nm;
        bit  tmo, fire, hit;
        if (rst) begin
            m_mode = 0; m_ah = 0; m_am = 0; m_phase = 0; m_beep = 0; m_left = 0;
            m_idle = 0; m_held = 0; m_inc_min = 0; m_inc_hour = 0;
            prev_bm = 0; prev_bi = 0; prev_sz = 0; pend_mode = 0; pend_press = 0; pend_rep = 0;
        end else begin
            nm = m_mode;
            tmo = 0;
            fire = pend_press || pend_rep;
            m_inc_min = 0;
            m_inc_hour = 0;
            if (pend_mode) begin
                nm = (m_mode + 1) % 5;
                m_idle = 0;
            end else begin
                if (pend_press) m_idle = 0;
                else if (m_mode != 0 && tick_1hz) begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_S) begin nm = 0; m_idle = 0; tmo = 1; end
                end
                if (!tmo && fire) begin
                    case (m_mode)
                        1: m_inc_hour = 1;
                        2: m_inc_min = 1;
                        3: m_ah = (m_ah + 1) % 24;
                        4: m_am = (m_am + 1) % 60;
                        default: ;
                    endcase
                end
            end
            hit = (m_mode == 0) && alarm_en && cur_sec_zero && !prev_sz
                  && (int'(cur_h_t) * 10 + int'(cur_h_o) == m_ah)
                  && (int'(cur_m_t) * 10 + int'(cur_m_o) == m_am);
            if (!alarm_en || pend_press || pend_mode || m_mode != 0) m_beep = 0;
            else if (hit) begin m_beep = 1; m_left = BEEP_S; end
            else if (m_beep != 0 && tick_1hz) begin
                m_left--;
                if (m_left == 0) m_beep = 0;
            end
            if (tick_4hz) m_phase = 1 - m_phase;
            pend_mode  = btn_mode && !prev_bm;
            pend_press = btn_inc && !prev_bi;
            pend_rep   = 0;
            if (btn_inc && prev_bi) begin
                if (tick_4hz) begin
                    m_held++;
                    pend_rep = (m_held > REPEAT_DLY);
                end
            end else m_held = 0;
            prev_bm = btn_mode;
            prev_bi = btn_inc;
            prev_sz = cur_sec_zero;
            m_mode = nm;
        end
    end

    // Every cycle after the first reset edge, every output is compared with the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("mode", int'(mode), m_mode);
            checkOutput("run_en", int'(run_en), (m_mode == 0) ? 1 : 0);
            checkOutput("disp_alarm", int'(disp_alarm), (m_mode == 3 || m_mode == 4) ? 1 : 0);
            checkOutput("blank", int'(blank), (m_phase == 0) ? 0 :
                        (m_mode == 1 || m_mode == 3) ? 48 : (m_mode == 2 || m_mode == 4) ? 12 : 0);
            checkOutput("beep", int'(beep), m_beep);
            checkOutput("inc_min", int'(inc_min), m_inc_min);
            checkOutput("inc_hour", int'(inc_hour), m_inc_hour);
            checkOutput("alarm_hour", int'(alm_h_t) * 10 + int'(alm_h_o), m_ah);
            checkOutput("alarm_min", int'(alm_m_t) * 10 + int'(alm_m_o), m_am);
            checkOutput("alarm_h_digit_ok", (alm_h_o <= 4'd9) ? 1 : 0, 1);
        end
    end

    task automatic applyStimulus(input logic bm, input logic bi, input logic t1, input logic t4);
        btn_mode = bm;
        btn_inc  = bi;
        tick_1hz = t1;
        tick_4hz = t4;
        @(posedge clk);
        #2;
    endtask

    task automatic pressMode(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
    endtask

    task automatic setCur(input int h, input int m);
        cur_h_t = 4'(h / 10); cur_h_o = 4'(h % 10);
        cur_m_t = 4'(m / 10); cur_m_o = 4'(m % 10);
    endtask

    initial begin
        int exp_mode [5];
        exp_mode = '{1, 2, 3, 4, 0};

        rst = 1'b1;
        @(posedge clk);
        #2;
        check_en = 1'b1;
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_run_en", int'(run_en), 1);
        checkOutput("reset_alarm", int'({alm_h_t, alm_h_o, alm_m_t, alm_m_o}), 0);
        checkOutput("reset_beep_blank", int'({beep, disp_alarm, blank}), 0);

        applyStimulus(1, 0, 0, 0);
        checkOutput("mode_not_yet", int'(mode), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mode_seq0", int'(mode), exp_mode[0]);
        for (int i = 1; i < 5; i++) begin
            pressMode(1);
            checkOutput("mode_seq", int'(mode), exp_mode[i]);
            checkOutput("disp_alarm_seq", int'(disp_alarm), (i == 2 || i == 3) ? 1 : 0);
        end

        pressMode(2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("inc_min_early", int'(inc_min), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("inc_min_pulse", int'(inc_min), 1);
        checkOutput("set_run_en", int'(run_en), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("inc_min_done", int'(inc_min), 0);

        pressMode(1);
        pressInc(23);
        checkOutput("alm_hour_23", int'({alm_h_t, alm_h_o}), 8'h23);
        pressInc(1);
        checkOutput("alm_hour_wrap", int'({alm_h_t, alm_h_o}), 8'h00);
        pressMode(1);
        pressInc(59);
        checkOutput("alm_min_59", int'({alm_m_t, alm_m_o}), 8'h59);
        pressInc(1);
        checkOutput("alm_min_wrap", int'({alm_m_t, alm_m_o}), 8'h00);
        checkOutput("alm_hour_kept", int'({alm_h_t, alm_h_o}), 8'h00);

        applyStimulus(0, 1, 0, 0);
        for (int t = 0; t < 8; t++) begin
            applyStimulus(0, 1, 0, 1);
            repeat (3) applyStimulus(0, 1, 0, 0);
        end
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOutput("auto_repeat_7", int'({alm_m_t, alm_m_o}), 8'h07);

        pressMode(4);
        pressInc(7);
        pressMode(1);
        pressInc(23);
        pressMode(1);
        checkOutput("alarm_0730", int'({alm_h_t, alm_h_o, alm_m_t, alm_m_o}), 16'h0730);
        alarm_en = 1'b1;
        setCur(7, 30);
        cur_sec_zero = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("beep_idle", int'(beep), 0);
        cur_sec_zero = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("beep_rise", int'(beep), 1);
        for (int s = 1; s <= BEEP_S; s++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
            if (s == BEEP_S - 1) checkOutput("beep_59s", int'(beep), 1);
        end
        checkOutput("beep_60s_off", int'(beep), 0);
        cur_sec_zero = 1'b0;
        applyStimulus(0, 0, 0, 0);
        cur_sec_zero = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("beep_rise2", int'(beep), 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("beep_before_silence", int'(beep), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("beep_silenced", int'(beep), 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("beep_no_retrigger", int'(beep), 0);
        cur_sec_zero = 1'b0;

        pressMode(1);
        for (int s = 1; s <= TIMEOUT_S; s++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
            if (s == TIMEOUT_S - 1) checkOutput("timeout_15", int'(mode), 1);
        end
        checkOutput("timeout_16", int'(mode), 0);

        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("both_mode", int'(mode), 1);
        checkOutput("both_no_inc", int'(inc_hour), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("both_no_inc_late", int'(inc_hour), 0);
        repeat (8) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mode_hold_once", int'(mode), 2);

        for (int c = 0; c < 6000; c++) begin
            logic bm, bi;
            bm = btn_mode ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 149) == 0);
            bi = btn_inc ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 29) == 0) setCur(m_ah, m_am);
            else if ($urandom_range(0, 29) == 0) setCur($urandom_range(0, 23), $urandom_range(0, 59));
            if ($urandom_range(0, 7) == 0) cur_sec_zero = ~cur_sec_zero;
            rst = ($urandom_range(0, 799) == 0);
            applyStimulus(bm, bi, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
